// File: rtl/ctrl_pkg.sv
// Shared types for the control-decoder opcode feeder.
package ctrl_pkg;

  localparam int unsigned OP_W   = 7;
  localparam int unsigned HOLD_W = 2;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [HOLD_W-1:0] hold;
  } entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } issue_state_t;

endpackage

// File: rtl/ctrl_opcode_feeder_if.sv
// Upstream opcode handshake, flush, and decoder-side presentation signals.
interface ctrl_opcode_feeder_if
  import ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [HOLD_W-1:0] in_hold;
  logic              flush;
  logic              op_valid;
  logic [OP_W-1:0]   op_out;
  logic              op_first;
  logic              op_last;
  logic              dec_ready;
  logic [LVL_W-1:0]  fifo_level;

  modport master (
    output in_valid, in_op, in_hold, flush, dec_ready,
    input  in_ready, op_valid, op_out, op_first, op_last, fifo_level
  );

  modport slave (
    input  in_valid, in_op, in_hold, flush, dec_ready,
    output in_ready, op_valid, op_out, op_first, op_last, fifo_level
  );

endinterface

// File: rtl/ctrl_sync_fifo.sv
// Synchronous FIFO of opcode entries; pointers carry one extra wrap bit.
module ctrl_sync_fifo
  import ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 wdata,
  output entry_t                 rdata_c,
  output logic                   full_c,
  output logic                   empty_c,
  output logic [$clog2(DEPTH):0] level_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  entry_t      mem [DEPTH];

  // Pointer update; flush and reset both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata_c = mem[rd_ptr[AW-1:0]];
  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level_c = wr_ptr - rd_ptr;

endmodule

// File: rtl/ctrl_opcode_feeder.sv
// Buffers opcodes and presents each to the decoder for 1 + hold accepted beats.
module ctrl_opcode_feeder
  import ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ctrl_opcode_feeder_if.slave  bus
);

  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  entry_t       head;
  entry_t       wentry;
  logic [$clog2(DEPTH):0] level;

  issue_state_t      state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              valid_q, valid_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              accept;

  assign bus.in_ready = !full && !bus.flush && !rst;
  assign push         = bus.in_valid && bus.in_ready;
  assign wentry       = '{op: bus.in_op, hold: bus.in_hold};

  ctrl_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (bus.flush),
    .push    (push),
    .pop     (pop),
    .wdata   (wentry),
    .rdata_c (head),
    .full_c  (full),
    .empty_c (empty),
    .level_c (level)
  );

  assign accept = valid_q && bus.dec_ready;

  // Issue register and hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  // Next-state: load from FIFO head, count down accepted beats, or retire.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    valid_d = valid_q;
    first_d = first_q;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          op_d    = head.op;
          cnt_d   = head.hold;
          first_d = 1'b1;
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (accept) begin
          if (cnt_q != '0) begin
            cnt_d   = cnt_q - HOLD_W'(1);
            first_d = 1'b0;
          end else if (!empty) begin
            pop     = 1'b1;
            op_d    = head.op;
            cnt_d   = head.hold;
            first_d = 1'b1;
          end else begin
            valid_d = 1'b0;
            first_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over everything but keeps the last presented opcode.
    if (bus.flush) begin
      pop     = 1'b0;
      op_d    = op_q;
      cnt_d   = '0;
      valid_d = 1'b0;
      first_d = 1'b0;
      state_d = IDLE;
    end

    last_d = valid_d && (cnt_d == '0);
  end

  assign bus.op_valid   = valid_q;
  assign bus.op_out     = op_q;
  assign bus.op_first   = first_q;
  assign bus.op_last    = last_q;
  assign bus.fifo_level = level;

endmodule

// File: tb/tb_ctrl_opcode_feeder.sv
// Directed bench for the opcode feeder: vector table plus hand sequences.
module tb_ctrl_opcode_feeder;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  ctrl_opcode_feeder_if #(.DEPTH(4)) bus ();

  ctrl_opcode_feeder #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [6:0] op;
    logic [1:0] hold;
    logic       dr;
    logic       fl;
    logic       rdy;
    logic       v;
    logic [6:0] eop;
    logic       f;
    logic       l;
    logic [2:0] lvl;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  function automatic vec_t mkv(input logic r, input logic iv, input logic [6:0] op,
                               input logic [1:0] h, input logic dr, input logic fl,
                               input logic rdy, input logic v, input logic [6:0] eop,
                               input logic f, input logic l, input logic [2:0] lvl);
    vec_t t;
    t.rst = r; t.iv = iv; t.op = op; t.hold = h; t.dr = dr; t.fl = fl;
    t.rdy = rdy; t.v = v; t.eop = eop; t.f = f; t.l = l; t.lvl = lvl;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [6:0] op,
                       input logic [1:0] h, input logic dr, input logic fl);
    rst           = r;
    bus.in_valid  = iv;
    bus.in_op     = op;
    bus.in_hold   = h;
    bus.dec_ready = dr;
    bus.flush     = fl;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [6:0] op,
                           input logic f, input logic l, input logic [2:0] lvl);
    check({tag, "_valid"}, 32'(bus.op_valid), 32'(v));
    check({tag, "_op"},    32'(bus.op_out),   32'(op));
    check({tag, "_first"}, 32'(bus.op_first), 32'(f));
    check({tag, "_last"},  32'(bus.op_last),  32'(l));
    check({tag, "_level"}, 32'(bus.fifo_level), 32'(lvl));
  endtask

  task automatic apply(input vec_t t, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    drive(t.rst, t.iv, t.op, t.hold, t.dr, t.fl);
    #1;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'(t.rdy));
    @(posedge clk);
    #1;
    check_out(tag, t.v, t.eop, t.f, t.l, t.lvl);
  endtask

  logic [1:0] exp_cnt;
  logic       exp_v;
  logic       exp_f;
  logic       push_ok;
  logic       acc;
  int         pushed;
  int         popped;
  int         cyc;
  logic       dr_pat [7];

  initial begin
    n_checks = 0;
    n_err    = 0;
    drive(1'b1, 1'b0, 7'h00, 2'd0, 1'b0, 1'b0);

    //                 rst iv  op     h     dr    fl  | rdy   v     op     f     l    lvl
    vecs[0]  = mkv(1'b1,1'b0,7'h00,2'd0,1'b1,1'b0, 1'b0,1'b0,7'h00,1'b0,1'b0,3'd0);
    vecs[1]  = mkv(1'b0,1'b1,7'h2A,2'd0,1'b1,1'b0, 1'b1,1'b0,7'h00,1'b0,1'b0,3'd1);
    vecs[2]  = mkv(1'b0,1'b0,7'h00,2'd0,1'b1,1'b0, 1'b1,1'b1,7'h2A,1'b1,1'b1,3'd0);
    vecs[3]  = mkv(1'b0,1'b0,7'h00,2'd0,1'b1,1'b0, 1'b1,1'b0,7'h2A,1'b0,1'b0,3'd0);
    vecs[4]  = mkv(1'b0,1'b1,7'h11,2'd2,1'b1,1'b0, 1'b1,1'b0,7'h2A,1'b0,1'b0,3'd1);
    vecs[5]  = mkv(1'b0,1'b0,7'h00,2'd0,1'b1,1'b0, 1'b1,1'b1,7'h11,1'b1,1'b0,3'd0);
    vecs[6]  = mkv(1'b0,1'b0,7'h00,2'd0,1'b1,1'b0, 1'b1,1'b1,7'h11,1'b0,1'b0,3'd0);
    vecs[7]  = mkv(1'b0,1'b0,7'h00,2'd0,1'b1,1'b0, 1'b1,1'b1,7'h11,1'b0,1'b1,3'd0);
    vecs[8]  = mkv(1'b0,1'b0,7'h00,2'd0,1'b1,1'b0, 1'b1,1'b0,7'h11,1'b0,1'b0,3'd0);
    vecs[9]  = mkv(1'b0,1'b1,7'h01,2'd0,1'b0,1'b0, 1'b1,1'b0,7'h11,1'b0,1'b0,3'd1);
    vecs[10] = mkv(1'b0,1'b1,7'h02,2'd0,1'b0,1'b0, 1'b1,1'b1,7'h01,1'b1,1'b1,3'd1);
    vecs[11] = mkv(1'b0,1'b1,7'h03,2'd0,1'b0,1'b0, 1'b1,1'b1,7'h01,1'b1,1'b1,3'd2);
    vecs[12] = mkv(1'b0,1'b1,7'h04,2'd0,1'b0,1'b0, 1'b1,1'b1,7'h01,1'b1,1'b1,3'd3);
    vecs[13] = mkv(1'b0,1'b1,7'h05,2'd0,1'b0,1'b0, 1'b1,1'b1,7'h01,1'b1,1'b1,3'd4);
    vecs[14] = mkv(1'b0,1'b1,7'h06,2'd0,1'b0,1'b0, 1'b0,1'b1,7'h01,1'b1,1'b1,3'd4);
    vecs[15] = mkv(1'b0,1'b0,7'h00,2'd0,1'b1,1'b0, 1'b0,1'b1,7'h02,1'b1,1'b1,3'd3);
    vecs[16] = mkv(1'b0,1'b0,7'h00,2'd0,1'b1,1'b0, 1'b1,1'b1,7'h03,1'b1,1'b1,3'd2);
    vecs[17] = mkv(1'b0,1'b0,7'h00,2'd0,1'b1,1'b0, 1'b1,1'b1,7'h04,1'b1,1'b1,3'd1);
    vecs[18] = mkv(1'b0,1'b0,7'h00,2'd0,1'b1,1'b0, 1'b1,1'b1,7'h05,1'b1,1'b1,3'd0);
    vecs[19] = mkv(1'b0,1'b0,7'h00,2'd0,1'b1,1'b0, 1'b1,1'b0,7'h05,1'b0,1'b0,3'd0);
    vecs[20] = mkv(1'b0,1'b1,7'h31,2'd1,1'b0,1'b0, 1'b1,1'b0,7'h05,1'b0,1'b0,3'd1);
    vecs[21] = mkv(1'b0,1'b1,7'h32,2'd0,1'b0,1'b0, 1'b1,1'b1,7'h31,1'b1,1'b0,3'd1);
    vecs[22] = mkv(1'b0,1'b1,7'h33,2'd0,1'b0,1'b0, 1'b1,1'b1,7'h31,1'b1,1'b0,3'd2);
    vecs[23] = mkv(1'b0,1'b1,7'h34,2'd0,1'b0,1'b0, 1'b1,1'b1,7'h31,1'b1,1'b0,3'd3);
    vecs[24] = mkv(1'b0,1'b1,7'h35,2'd0,1'b1,1'b1, 1'b0,1'b0,7'h31,1'b0,1'b0,3'd0);
    vecs[25] = mkv(1'b0,1'b0,7'h00,2'd0,1'b1,1'b0, 1'b1,1'b0,7'h31,1'b0,1'b0,3'd0);
    vecs[26] = mkv(1'b0,1'b1,7'h36,2'd0,1'b1,1'b0, 1'b1,1'b0,7'h31,1'b0,1'b0,3'd1);
    vecs[27] = mkv(1'b0,1'b0,7'h00,2'd0,1'b1,1'b0, 1'b1,1'b1,7'h36,1'b1,1'b1,3'd0);
    vecs[28] = mkv(1'b0,1'b0,7'h00,2'd0,1'b1,1'b0, 1'b1,1'b0,7'h36,1'b0,1'b0,3'd0);

    @(posedge clk);
    #1;
    for (int i = 0; i < NV; i++) apply(vecs[i], i);

    // Hold=3 opcode with intermittent dec_ready: only accepted beats count.
    drive(1'b0, 1'b1, 7'h45, 2'd3, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 7'h00, 2'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    exp_cnt = 2'd3; exp_v = 1'b1; exp_f = 1'b1;
    check_out("hold_load", exp_v, 7'h45, exp_f, 1'b0, 3'd0);
    dr_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 7; k++) begin
      bus.dec_ready = dr_pat[k];
      @(posedge clk); #1;
      if (dr_pat[k]) begin
        if (exp_cnt == 2'd0) begin
          exp_v = 1'b0; exp_f = 1'b0;
        end else begin
          exp_cnt = exp_cnt - 2'd1; exp_f = 1'b0;
        end
      end
      check_out($sformatf("hold_b%0d", k), exp_v, 7'h45, exp_f,
                exp_v && (exp_cnt == 2'd0), 3'd0);
    end

    // Reset in the middle of a hold with entries still queued.
    drive(1'b0, 1'b1, 7'h5A, 2'd3, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 7'h5B, 2'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 7'h5C, 2'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 7'h00, 2'd0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_out("pre_rst", 1'b1, 7'h5A, 1'b0, 1'b0, 3'd2);
    drive(1'b1, 1'b1, 7'h5D, 2'd0, 1'b1, 1'b0);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'(0));
    @(posedge clk); #1;
    check_out("mid_rst", 1'b0, 7'h00, 1'b0, 1'b0, 3'd0);
    drive(1'b0, 1'b0, 7'h00, 2'd0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_out("post_rst", 1'b0, 7'h00, 1'b0, 1'b0, 3'd0);

    // Pointer wrap: 3*DEPTH opcodes through a throttled consumer, in order.
    pushed = 0; popped = 0; cyc = 0;
    while (popped < 12 && cyc < 300) begin
      drive(1'b0, pushed < 12, 7'(pushed), 2'd0, (cyc % 3) == 0, 1'b0);
      #1;
      push_ok = bus.in_valid && bus.in_ready;
      acc     = bus.op_valid && bus.dec_ready;
      if (acc) begin
        check($sformatf("wrap_order%0d", popped), 32'(bus.op_out), 32'(popped));
        popped++;
      end
      @(posedge clk); #1;
      if (push_ok) pushed++;
      cyc++;
    end
    if (popped < 12) check("wrap_timeout", 32'(popped), 32'(12));
    drive(1'b0, 1'b0, 7'h00, 2'd0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_out("wrap_done", 1'b0, 7'd11, 1'b0, 1'b0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_opcode_feeder.md
Name: ctrl_opcode_feeder

Overview:
Front-end stage that feeds the combinational control decoder. It accepts opcodes from the fetch/issue path over a valid/ready handshake and buffers them in a small FIFO. It then presents one 7-bit opcode at a time to the decoder, holding each one stable for a programmable number of beats. Downstream back-pressure (dec_ready) stalls the presentation, and a synchronous flush discards all queued and in-flight work.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
HOLD_W, 2, width of per-opcode hold count; an opcode is presented for 1 + hold accepted beats
OP_W, 7, opcode width; fixed to the decoder input width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  upstream opcode valid
in_ready  out  1  feeder can accept an opcode this cycle
in_op  in  OP_W  opcode from fetch
in_hold  in  HOLD_W  extra hold beats for this opcode
flush  in  1  synchronous discard of FIFO and issue register
op_valid  out  1  op_out is a live opcode for the decoder
op_out  out  OP_W  registered opcode driving the decoder inputs
op_first  out  1  first beat of the current opcode
op_last  out  1  final beat of the current opcode (op_valid and count equal to 0)
dec_ready  in  1  decoder/consumer accepts the current beat
fifo_level  out  $clog2(DEPTH)+1  number of occupied FIFO entries

Behaviour:
- Reset (rst=1 at an edge): FIFO empty, fifo_level=0, op_valid=0, op_out=0, op_first=0, op_last=0, counter=0, state=IDLE. in_ready=0 while rst is high.
- Push: in_valid & in_ready stores {in_op, in_hold} at the write pointer. in_ready = !full & !flush & !rst. No bypass when full: a pop in the same cycle does not raise in_ready.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. Full when the low bits are equal and the MSBs differ; empty when all bits are equal.
- A beat is accepted when op_valid & dec_ready.
- Issue state machine:
  - IDLE (op_valid=0): if the FIFO is non-empty, pop the head, load op_out and the counter (counter = hold), set op_first=1, op_valid=1, and go to ISSUE.
  - ISSUE (op_valid=1): on an accepted beat with counter != 0, decrement the counter and clear op_first. op_out stays unchanged.
  - On an accepted beat with counter == 0 (op_last):
    - if the FIFO is non-empty, pop and reload in the same edge, with op_first=1 (back-to-back, no bubble);
    - otherwise op_valid=0 and return to IDLE.
  - With no accepted beat (dec_ready=0), all issue outputs hold their values.
- Latency: an opcode pushed into an empty feeder at edge N is popped at edge N+1, so op_valid rises one cycle after the push edge. Steady-state throughput is one opcode per (1+hold) accepted beats.
- Simultaneous push and pop: allowed; fifo_level is unchanged.
- Pushing into an empty FIFO while IDLE: the entry is written at that edge and popped at the next edge; there is no combinational bypass.
- flush (any state): at the edge, FIFO empty, op_valid=0, op_first=0, counter=0, state=IDLE. op_out holds its last value. A concurrent in_valid is dropped because in_ready=0. flush has priority over push, pop and accept.
- rst mid-operation has the same effect as flush, plus op_out=0.
- op_out changes only on a load or on reset.

Decomposition:
- Shared package ctrl_pkg:
  - OP_W=7;
  - a packed struct entry_t {op, hold};
  - enum issue_state_t {IDLE, ISSUE}.
- Sub-module ctrl_sync_fifo (generic DEPTH x entry_t synchronous FIFO with push/pop/full/empty/level). The issue state machine and counter stay in the top.

Test Plan:
- Reset release, then push op 7'h2A with hold=0 while dec_ready=1 -> op_valid=1 with op_out=2A, op_first=1 and op_last=1 on the cycle after the push edge; op_valid=0 on the following cycle; fifo_level returns to 0.
- Push 7'h11 with hold=2, dec_ready=1 -> op_out=11 for exactly 3 cycles; op_first only on beat 1; op_last only on beat 3.
- Push 5 opcodes back-to-back with dec_ready=0 -> 1 is loaded into the issue register, 4 fill the FIFO; in_ready drops to 0 when fifo_level=4; the 6th in_valid is held off. Then raise dec_ready -> all 5 are issued in order with no bubbles (hold=0).
- Toggle dec_ready 1,0,1,0 during a hold=3 opcode -> the counter decrements only on accepted beats; op_out stays stable for 4 accepted beats.
- Assert flush with fifo_level=3 and op_valid=1, with in_valid high in the same cycle -> next cycle op_valid=0, fifo_level=0, the input is dropped; a subsequent push is issued normally.
- Assert rst mid-hold -> next cycle all outputs are 0; pointer wrap is checked by pushing and popping 3*DEPTH opcodes (values 0..11) and confirming in-order delivery.
